// File: rtl/game_pkg.sv
// Shared state encoding and sizing helpers for the game flow controller.
package game_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_SPLASH = 2'd0,
    ST_PLAY   = 2'd1,
    ST_END    = 2'd2,
    ST_PAUSE  = 2'd3
  } game_state_e;

  // Width of an index or counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for a debounced button level.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic armed_q;

  // The first clock after reset only samples the input, so a button held through reset
  // release has to be let go and pressed again before it registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q    <= in;
      armed_q <= 1'b1;
    end
  end

  assign rise = in & ~in_q & armed_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game flow controller: SPLASH -> PLAY <-> PAUSE -> END, with win evaluation and END timeout.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned WIN_MARGIN  = 0,
  parameter int unsigned END_TIMEOUT = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               restart,
  input  logic                               pause,
  input  logic [NUM_PLAYERS*SCORE_W-1:0]     scores,
  output logic [STATE_W-1:0]                 cur_state,
  output logic [idx_w(NUM_PLAYERS)-1:0]      winner,
  output logic                               tie,
  output logic                               state_entry
);

  localparam int unsigned WinW = idx_w(NUM_PLAYERS);
  localparam int unsigned CntW = idx_w(END_TIMEOUT);

  logic start_rise, restart_rise, pause_rise;

  edge_detect u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (start),
    .rise  (start_rise)
  );

  edge_detect u_restart_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (restart),
    .rise  (restart_rise)
  );

  edge_detect u_pause_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (pause),
    .rise  (pause_rise)
  );

  // Win evaluation
  logic [SCORE_W-1:0]     score [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] qualify;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_win
    logic ok;

    assign score[i] = scores[i*SCORE_W +: SCORE_W];

    // Lead is taken in SCORE_W+1 bits and only when score_i >= score_j, so it never wraps.
    always_comb begin
      logic [SCORE_W:0] diff;
      diff = '0;
      ok   = (32'(score[i]) >= WIN_SCORE);
      if (WIN_MARGIN > 0) begin
        for (int j = 0; j < NUM_PLAYERS; j++) begin
          if (j != i) begin
            diff = {1'b0, score[i]} - {1'b0, score[j]};
            if ((score[i] < score[j]) || (32'(diff) < WIN_MARGIN)) begin
              ok = 1'b0;
            end
          end
        end
      end
    end

    assign qualify[i] = ok;
  end

  logic [WinW-1:0] win_idx;
  logic            any_win;
  logic            multi_win;

  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (qualify[i]) begin
        win_idx = WinW'(i);
      end
    end
    any_win   = |qualify;
    multi_win = |(qualify & (qualify - NUM_PLAYERS'(1)));
  end

  // State machine
  game_state_e     state_q, state_d;
  logic [WinW-1:0] winner_q, winner_d;
  logic            tie_q, tie_d;
  logic            entry_q, entry_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SPLASH;
      winner_q <= '0;
      tie_q    <= 1'b0;
      entry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_SPLASH: begin
        if (start_rise) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (restart_rise) begin
          state_d = ST_SPLASH;
        end else if (any_win) begin
          state_d  = ST_END;
          winner_d = win_idx;
          tie_d    = multi_win;
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (restart_rise) begin
          state_d = ST_SPLASH;
        end else if (pause_rise) begin
          state_d = ST_PLAY;
        end
      end
      ST_END: begin
        if (restart_rise) begin
          state_d = ST_SPLASH;
        end else if ((END_TIMEOUT > 0) && (cnt_q == CntW'(END_TIMEOUT - 1))) begin
          state_d = ST_SPLASH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_SPLASH;
      end
    endcase

    if (state_d == ST_SPLASH) begin
      winner_d = '0;
      tie_d    = 1'b0;
    end
    if (state_d != ST_END || state_q != ST_END) begin
      cnt_d = '0;
    end
    entry_d = (state_d != state_q);
  end

  assign cur_state   = state_q;
  assign winner      = winner_q;
  assign tie         = tie_q;
  assign state_entry = entry_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed vector bench for game_ctrl_fsm: margin-0/timeout-4 and margin-2/no-timeout builds.
module tb_game_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start_a = 0, restart_a = 0, pause_a = 0;
  logic [5:0] scores_a = '0;
  logic [1:0] state_a;
  logic [0:0] winner_a;
  logic       tie_a, entry_a;

  logic       start_b = 0, restart_b = 0, pause_b = 0;
  logic [5:0] scores_b = '0;
  logic [1:0] state_b;
  logic [0:0] winner_b;
  logic       tie_b, entry_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_ctrl_fsm #(
    .NUM_PLAYERS (2),
    .SCORE_W     (3),
    .WIN_SCORE   (5),
    .WIN_MARGIN  (0),
    .END_TIMEOUT (4)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .restart     (restart_a),
    .pause       (pause_a),
    .scores      (scores_a),
    .cur_state   (state_a),
    .winner      (winner_a),
    .tie         (tie_a),
    .state_entry (entry_a)
  );

  game_ctrl_fsm #(
    .NUM_PLAYERS (2),
    .SCORE_W     (3),
    .WIN_SCORE   (5),
    .WIN_MARGIN  (2),
    .END_TIMEOUT (0)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .restart     (restart_b),
    .pause       (pause_b),
    .scores      (scores_b),
    .cur_state   (state_b),
    .winner      (winner_b),
    .tie         (tie_b),
    .state_entry (entry_b)
  );

  typedef struct {
    logic       sel;  // 0: dut_a, 1: dut_b
    logic       st, rs, ps;
    logic [2:0] p1, p0;
    logic [1:0] es;
    logic       ew, et, ee;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic sel, input logic st, input logic rs, input logic ps,
                     input int p1, input int p0,
                     input int es, input int ew, input int et, input int ee);
    vec_t v;
    v.sel = sel; v.st = st; v.rs = rs; v.ps = ps;
    v.p1 = 3'(p1); v.p0 = 3'(p0);
    v.es = 2'(es); v.ew = 1'(ew); v.et = 1'(et); v.ee = 1'(ee);
    tab.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input int es, input int ew, input int et, input int ee);
    check({name, " state"}, int'(state_a), es);
    check({name, " winner"}, int'(winner_a), ew);
    check({name, " tie"}, int'(tie_a), et);
    check({name, " entry"}, int'(entry_a), ee);
  endtask

  initial begin
    // dut_a: win detection, tie, pause, END timeout of 4 cycles
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 3, 5, 2, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 5, 5, 2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 1, 6, 6, 3, 0, 0, 0);
    add(0, 0, 0, 0, 6, 6, 3, 0, 0, 0);
    add(0, 0, 0, 1, 6, 6, 1, 0, 0, 1);
    add(0, 0, 0, 1, 6, 6, 2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // dut_b: margin of 2, END never times out
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 5, 4, 1, 0, 0, 0);
    add(1, 0, 0, 0, 5, 6, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    add(1, 0, 0, 0, 3, 6, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 7, 0, 2, 1, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);

    // Reset state
    step();
    step();
    chk_a("reset a", 0, 0, 0, 0);
    check("reset b state", int'(state_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    foreach (tab[i]) begin
      if (tab[i].sel == 1'b0) begin
        start_a = tab[i].st; restart_a = tab[i].rs; pause_a = tab[i].ps;
        scores_a = {tab[i].p1, tab[i].p0};
      end else begin
        start_b = tab[i].st; restart_b = tab[i].rs; pause_b = tab[i].ps;
        scores_b = {tab[i].p1, tab[i].p0};
      end
      step();
      if (tab[i].sel == 1'b0) begin
        chk_a($sformatf("row %0d", i), tab[i].es, tab[i].ew, tab[i].et, tab[i].ee);
      end else begin
        check($sformatf("row %0d state", i), int'(state_b), tab[i].es);
        check($sformatf("row %0d winner", i), int'(winner_b), tab[i].ew);
        check($sformatf("row %0d tie", i), int'(tie_b), tab[i].et);
        check($sformatf("row %0d entry", i), int'(entry_b), tab[i].ee);
      end
    end

    // Restart on the second cycle of END
    start_a = 1; step(); check("seq1 play", int'(state_a), 1);
    start_a = 0; scores_a = {3'd0, 3'd5}; step(); check("seq1 end", int'(state_a), 2);
    scores_a = '0; step(); check("seq1 end hold", int'(state_a), 2);
    restart_a = 1; step(); chk_a("seq1 restart", 0, 0, 0, 1);

    // Restart and a win in the same PLAY cycle: restart takes priority
    restart_a = 0; start_a = 1; step(); check("seq2 play", int'(state_a), 1);
    restart_a = 1; scores_a = {3'd5, 3'd5}; step(); chk_a("seq2 restart+win", 0, 0, 0, 1);

    // Start and restart rising together in SPLASH
    start_a = 0; restart_a = 0; scores_a = '0; step(); check("seq3 idle", int'(state_a), 0);
    start_a = 1; restart_a = 1; step(); chk_a("seq3 start+restart", 1, 0, 0, 1);

    // Asynchronous reset in the middle of PAUSE, with start held through it
    start_a = 0; restart_a = 0; pause_a = 1; step(); chk_a("seq4 pause", 3, 0, 0, 1);
    start_a = 1; pause_a = 0;
    #2 rst_n = 1'b0;
    #1 chk_a("seq4 async reset", 0, 0, 0, 0);

    // Button held through reset release must not fire
    @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();
    chk_a("seq5 held start", 0, 0, 0, 0);
    start_a = 0; step();
    start_a = 1; step(); chk_a("seq5 re-press", 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
